dcache_mem_responder: RTL and testbench

- Memory-side responder for the data cache's main-memory request interface. Services cacheblock refills, cacheblock writebacks and uncached (bypass) byte/half/word/double accesses.
- Implements the ack/done handshake the dcache FSM waits on: gnt_o in WAIT_MEMORY_*_ACK, rvalid_o in WAIT_MEMORY_*_DONE.
- Backed by a line-wide, byte-enabled storage array.
- Used as the synthesizable memory in FPGA bring-up and as the golden responder in dcache benches.

---
 rtl/dcache_pkg.sv | 78 +++++++
 rtl/dcache_mem_sram.sv | 44 ++++
 rtl/dcache_mem_responder.sv | 193 +++++++++++++++++++
 tb/tb_dcache_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared constants, types and helpers for the data cache and its memory-side
// responder.
//   PLEN                    physical address width
//   DCACHE_LINE_WIDTH       cache line width in bits
//   DCACHE_OFFSET_WIDTH     byte-offset bits within a line
//   CACHE_MEM_REQ_SIZE_*    encoding of mem_size (byte/half/word/double/line)
//   mem_resp_state_t        responder FSM states
//   size_to_line_mask()     byte mask of a sub-line access within a line
//   align_mem_addr()        byte address aligned to the access size
//   is_valid_mem_size()     1 for the five legal size encodings
// -----------------------------------------------------------------------------
package dcache_pkg;

  localparam int unsigned PLEN                = 56;
  localparam int unsigned DCACHE_LINE_WIDTH   = 128;
  localparam int unsigned DCACHE_LINE_BYTES   = DCACHE_LINE_WIDTH / 8;
  localparam int unsigned DCACHE_OFFSET_WIDTH = $clog2(DCACHE_LINE_BYTES);

  localparam logic [2:0] CACHE_MEM_REQ_SIZE_BYTE  = 3'b000;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_HALF  = 3'b001;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_WORD  = 3'b010;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_DWORD = 3'b011;
  localparam logic [2:0] CACHE_MEM_REQ_SIZE_LINE  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    RESP
  } mem_resp_state_t;

  function automatic logic is_valid_mem_size(input logic [2:0] size);
    return (size == CACHE_MEM_REQ_SIZE_BYTE)  || (size == CACHE_MEM_REQ_SIZE_HALF) ||
           (size == CACHE_MEM_REQ_SIZE_WORD)  || (size == CACHE_MEM_REQ_SIZE_DWORD) ||
           (size == CACHE_MEM_REQ_SIZE_LINE);
  endfunction

  // Contiguous ones covering the access, shifted to its aligned lane offset.
  // A full-line access covers every byte; an illegal size covers none.
  function automatic logic [DCACHE_LINE_BYTES-1:0] size_to_line_mask(
    input logic [2:0]                     size,
    input logic [DCACHE_OFFSET_WIDTH-1:0] offset
  );
    logic [DCACHE_LINE_BYTES-1:0] mask;
    mask = '0;
    case (size)
      CACHE_MEM_REQ_SIZE_BYTE:  mask[0]   = 1'b1;
      CACHE_MEM_REQ_SIZE_HALF:  mask[1:0] = '1;
      CACHE_MEM_REQ_SIZE_WORD:  mask[3:0] = '1;
      CACHE_MEM_REQ_SIZE_DWORD: mask[7:0] = '1;
      default:                  mask      = '0;
    endcase
    if (size == CACHE_MEM_REQ_SIZE_LINE) begin
      return '1;
    end
    return mask << offset;
  endfunction

  // Same alignment the cache applies when it forms the request address.
  function automatic logic [PLEN-1:0] align_mem_addr(
    input logic [PLEN-1:0] addr,
    input logic [2:0]      size
  );
    logic [PLEN-1:0] aligned;
    aligned = addr;
    case (size)
      CACHE_MEM_REQ_SIZE_HALF:  aligned[0]   = 1'b0;
      CACHE_MEM_REQ_SIZE_WORD:  aligned[1:0] = '0;
      CACHE_MEM_REQ_SIZE_DWORD: aligned[2:0] = '0;
      CACHE_MEM_REQ_SIZE_LINE:  aligned[DCACHE_OFFSET_WIDTH-1:0] = '0;
      default:                  aligned = addr;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/dcache_mem_sram.sv
// -----------------------------------------------------------------------------
// dcache_mem_sram
// Line-wide storage with per-byte write enable and a registered read port.
//   clk_i      clock
//   re_i       read enable; rdata_o updates at the following edge
//   we_i       write enable, qualified per byte by be_i
//   addr_i     line index
//   be_i       byte enables
//   wdata_i    write data
//   rdata_o    registered read data (holds until the next read)
// -----------------------------------------------------------------------------
module dcache_mem_sram #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned NUM_LINES  = 1024
) (
  input  logic                          clk_i,
  input  logic                          re_i,
  input  logic                          we_i,
  input  logic [$clog2(NUM_LINES)-1:0]  addr_i,
  input  logic [LINE_WIDTH/8-1:0]       be_i,
  input  logic [LINE_WIDTH-1:0]         wdata_i,
  output logic [LINE_WIDTH-1:0]         rdata_o
);

  logic [LINE_WIDTH-1:0] mem_q [NUM_LINES];

  // NOTE: storage has no reset so it maps onto block RAM; contents after
  // power-up are undefined and only written lines may be read back.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < LINE_WIDTH / 8; b++) begin
        if (be_i[b]) begin
          // NOTE: non-blocking so the read below in the same edge sees the
          // old contents and simulation matches the synthesized RAM.
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// dcache_mem_responder
// Memory-side responder for the data cache request interface: line refills,
// line writebacks and uncached sub-line accesses, backed by dcache_mem_sram.
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   mem_req_i      request valid, held until mem_gnt_o
//   mem_we_i       1 = write, 0 = read
//   mem_addr_i     physical byte address
//   mem_size_i     CACHE_MEM_REQ_SIZE_* encoding
//   mem_wdata_i    lane-placed write data
//   mem_be_i       lane-placed byte enables (ignored for full-line writes)
//   mem_gnt_o      one-cycle acknowledge
//   mem_rvalid_o   one-cycle completion, READ/WRITE_LATENCY cycles after gnt
//   mem_rdata_o    read data, non-zero only while mem_rvalid_o
//   mem_err_o      qualifies mem_rvalid_o: request rejected
// -----------------------------------------------------------------------------
module dcache_mem_responder
  import dcache_pkg::*;
#(
  parameter int unsigned LINE_WIDTH    = DCACHE_LINE_WIDTH,
  parameter int unsigned NUM_LINES     = 1024,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [PLEN-1:0]         mem_addr_i,
  input  logic [2:0]              mem_size_i,
  input  logic [LINE_WIDTH-1:0]   mem_wdata_i,
  input  logic [LINE_WIDTH/8-1:0] mem_be_i,
  output logic                    mem_gnt_o,
  output logic                    mem_rvalid_o,
  output logic [LINE_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_err_o
);

  localparam int unsigned BE_WIDTH = LINE_WIDTH / 8;
  localparam int unsigned IDX_W    = $clog2(NUM_LINES);
  localparam int unsigned MAX_LAT  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                    : WRITE_LATENCY;
  localparam int unsigned CNT_W    = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  mem_resp_state_t state_q, state_d;

  // Captured request
  logic                           we_q;
  logic                           err_q;
  logic [2:0]                     size_q;
  logic [IDX_W-1:0]               idx_q;
  logic [DCACHE_OFFSET_WIDTH-1:0] off_q;
  logic [LINE_WIDTH-1:0]          wdata_q;
  logic [BE_WIDTH-1:0]            be_q;
  logic [CNT_W-1:0]               cnt_q;

  logic [PLEN-1:0]       addr_aligned;
  logic                  addr_out_of_range;
  logic [BE_WIDTH-1:0]   line_mask;
  logic [BE_WIDTH-1:0]   write_mask;
  logic [LINE_WIDTH-1:0] read_bit_mask;
  logic                  sram_re;
  logic                  sram_we;
  logic [LINE_WIDTH-1:0] sram_rdata;
  logic                  lat_is_one;

  assign addr_aligned      = align_mem_addr(mem_addr_i, mem_size_i);
  assign addr_out_of_range = |addr_aligned[PLEN-1:DCACHE_OFFSET_WIDTH+IDX_W];

  assign line_mask  = size_to_line_mask(size_q, off_q);
  // Full-line writebacks write every byte whatever the byte enables say.
  assign write_mask = (size_q == CACHE_MEM_REQ_SIZE_LINE) ? '1 : (be_q & line_mask);

  always_comb begin
    for (int b = 0; b < BE_WIDTH; b++) begin
      read_bit_mask[b*8 +: 8] = {8{line_mask[b]}};
    end
  end

  assign lat_is_one = we_q ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);

  // ---------------------------------------------------------------------------
  // Request capture: only an IDLE cycle can accept a request, so anything on
  // the request lines while busy is ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state_q == IDLE && mem_req_i) begin
      we_q    <= mem_we_i;
      err_q   <= !is_valid_mem_size(mem_size_i) || addr_out_of_range;
      size_q  <= mem_size_i;
      idx_q   <= addr_aligned[DCACHE_OFFSET_WIDTH +: IDX_W];
      off_q   <= addr_aligned[DCACHE_OFFSET_WIDTH-1:0];
      wdata_q <= mem_wdata_i;
      be_q    <= mem_be_i;
    end
  end

  // Latency counter: loaded at the end of GRANT, counts down through WAIT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        GRANT:   cnt_q <= we_q ? WR_LOAD : RD_LOAD;
        WAIT:    cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem_req_i) state_d = GRANT;
      GRANT:   state_d = lat_is_one ? RESP : WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_gnt_o    = 1'b0;
    mem_rvalid_o = 1'b0;
    mem_err_o    = 1'b0;
    mem_rdata_o  = '0;
    sram_re      = 1'b0;
    sram_we      = 1'b0;
    unique case (state_q)
      GRANT: begin
        mem_gnt_o = 1'b1;
        // The storage access happens on the edge that ends GRANT, so a
        // reset before that edge drops the write entirely.
        sram_we   = we_q && !err_q;
        sram_re   = !we_q && !err_q;
      end
      RESP: begin
        mem_rvalid_o = 1'b1;
        mem_err_o    = err_q;
        // Read data was captured at GRANT and nothing has read the array
        // since, so the SRAM output still holds this request's line.
        if (!we_q && !err_q) begin
          mem_rdata_o = sram_rdata & read_bit_mask;
        end
      end
      default: ;
    endcase
  end

  dcache_mem_sram #(
    .LINE_WIDTH (LINE_WIDTH),
    .NUM_LINES  (NUM_LINES)
  ) u_sram (
    .clk_i   (clk_i),
    .re_i    (sram_re),
    .we_i    (sram_we),
    .addr_i  (idx_q),
    .be_i    (write_mask),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

`ifndef SYNTHESIS
  // The cache must hold mem_req_i until it sees the grant.
  req_held_until_gnt : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q == GRANT) |-> mem_req_i
  ) else $error("mem_req_i dropped before mem_gnt_o");
`endif

endmodule

// File: tb/tb_dcache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dcache_mem_responder
// Randomized bench with a byte-level reference memory and a response
// scoreboard; a monitor checks every completion against the expected queue.
// -----------------------------------------------------------------------------
module tb_dcache_mem_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_req = 1'b0;
  logic         mem_we = 1'b0;
  logic [55:0]  mem_addr = '0;
  logic [2:0]   mem_size = '0;
  logic [127:0] mem_wdata = '0;
  logic [15:0]  mem_be = '0;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic         mem_err;

  always #5 clk = ~clk;

  dcache_mem_responder #(
    .LINE_WIDTH    (128),
    .NUM_LINES     (1024),
    .READ_LATENCY  (RD_LAT),
    .WRITE_LATENCY (WR_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mem_req_i    (mem_req),
    .mem_we_i     (mem_we),
    .mem_addr_i   (mem_addr),
    .mem_size_i   (mem_size),
    .mem_wdata_i  (mem_wdata),
    .mem_be_i     (mem_be),
    .mem_gnt_o    (mem_gnt),
    .mem_rvalid_o (mem_rvalid),
    .mem_rdata_o  (mem_rdata),
    .mem_err_o    (mem_err)
  );

  typedef struct {
    logic         err;
    logic         chk_data;
    logic [127:0] rdata;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] model [1024];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-granular memory updated from the access rules directly.
  function automatic void model_apply(input logic we, input logic [55:0] addr,
                                      input logic [2:0] size, input logic [127:0] wdata,
                                      input logic [15:0] be, output exp_t e);
    int n, off, idx;
    e.err      = (size == 3'd4) || (size == 3'd5) || (size == 3'd6) || (addr >= 56'd16384);
    e.lat      = we ? WR_LAT : RD_LAT;
    e.chk_data = !we || e.err;
    e.rdata    = '0;
    if (!e.err) begin
      idx = int'(addr / 16);
      n   = (size == 3'd7) ? 16 : (1 << size);
      off = (int'(addr % 16) / n) * n;
      for (int i = off; i < off + n; i++) begin
        if (we && (size == 3'd7 || be[i])) model[idx][i*8 +: 8] = wdata[i*8 +: 8];
        if (!we) e.rdata[i*8 +: 8] = model[idx][i*8 +: 8];
      end
    end
  endfunction

  // Monitor / scoreboard
  int cyc = 0;
  int gnt_cyc = 0;
  int rv_cyc = 0;
  int gnt_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      gnt_cnt = 0;
    end else begin
      if (mem_gnt) begin
        gnt_cnt++;
        gnt_cyc = cyc;
      end
      if (mem_rvalid) begin
        rv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          check("latency", 128'(cyc - gnt_cyc), 128'(e.lat));
          check("gnt_per_rvalid", 128'(gnt_cnt), 128'd1);
          check("err", 128'(mem_err), 128'(e.err));
          if (e.chk_data) check("rdata", mem_rdata, e.rdata);
        end
        gnt_cnt = 0;
      end
    end
  end

  task automatic drive(input logic we, input logic [55:0] addr, input logic [2:0] size,
                       input logic [127:0] wdata, input logic [15:0] be);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_size  = size;
    mem_wdata = wdata;
    mem_be    = be;
  endtask

  task automatic wait_gnt();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mem_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", 128'd1, 128'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("rvalid_pending", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic txn(input logic we, input logic [55:0] addr, input logic [2:0] size,
                     input logic [127:0] wdata, input logic [15:0] be);
    exp_t e;
    model_apply(we, addr, size, wdata, be, e);
    exp_q.push_back(e);
    drive(we, addr, size, wdata, be);
    wait_gnt();
    @(posedge clk); #1;
    mem_req = 1'b0;
    drain();
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [2:0] size_tab [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

  initial begin
    logic [55:0] a;
    exp_t        e;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 128'(mem_gnt), 128'd0);
    check("rst_rvalid", 128'(mem_rvalid), 128'd0);
    check("rst_err", 128'(mem_err), 128'd0);
    check("rst_rdata", mem_rdata, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Initialise the working set of lines
    for (int i = 0; i < 16; i++) txn(1'b1, 56'(i * 16), 3'd7, rand_line(), 16'h0000);

    // Refill of a preloaded line
    txn(1'b1, 56'h1230, 3'd7, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0000);
    txn(1'b0, 56'h1230, 3'd7, '0, '0);
    txn(1'b0, 56'h1238, 3'd7, '0, '0);

    // Writeback with be = 0, then refill through an unaligned address
    txn(1'b1, 56'h40, 3'd7, {4{32'hDEADBEEF}}, 16'h0000);
    txn(1'b0, 56'h4C, 3'd7, '0, '0);

    // Bypass byte store to lane 5 and readback
    txn(1'b1, 56'h45, 3'd0, 128'hA5 << 40, 16'h0020);
    txn(1'b0, 56'h45, 3'd0, '0, '0);
    txn(1'b0, 56'h40, 3'd7, '0, '0);

    // Illegal size and out-of-range address leave storage untouched
    txn(1'b1, 56'h80, 3'd5, rand_line(), 16'hFFFF);
    txn(1'b0, 56'h80, 3'd6, '0, '0);
    txn(1'b1, 56'h4080, 3'd7, rand_line(), 16'hFFFF);
    txn(1'b0, 56'h4000, 3'd3, '0, '0);
    txn(1'b0, 56'h80, 3'd7, '0, '0);

    // Half/word/double lane placement at the top of a line
    txn(1'b1, 56'h3F, 3'd1, rand_line(), 16'hFFFF);
    txn(1'b1, 56'h37, 3'd3, rand_line(), 16'h7FFF);
    txn(1'b0, 56'h3E, 3'd2, '0, '0);
    txn(1'b0, 56'h30, 3'd7, '0, '0);

    // Busy: request held high across two back-to-back transactions
    model_apply(1'b0, 56'h20, 3'd7, '0, '0, e);
    exp_q.push_back(e);
    model_apply(1'b0, 56'h1234, 3'd2, '0, '0, e);
    exp_q.push_back(e);
    drive(1'b0, 56'h20, 3'd7, '0, '0);
    wait_gnt();
    @(posedge clk); #1;
    drive(1'b0, 56'h1234, 3'd2, '0, '0);
    wait_gnt();
    @(negedge clk); #1;
    check("busy_gnt_gap", 128'(gnt_cyc - rv_cyc), 128'd2);
    @(posedge clk); #1;
    mem_req = 1'b0;
    drain();

    // Reset during WAIT of a read: outputs clear at once, no completion
    drive(1'b0, 56'h10, 3'd7, '0, '0);
    wait_gnt();
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 128'(mem_gnt), 128'd0);
    check("midrst_rvalid", 128'(mem_rvalid), 128'd0);
    check("midrst_err", 128'(mem_err), 128'd0);
    check("midrst_rdata", mem_rdata, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    txn(1'b0, 56'h10, 3'd7, '0, '0);

    // Randomized traffic over the initialised lines
    for (int i = 0; i < 60; i++) begin
      a = 56'($urandom_range(0, 15) * 16 + $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = a | (56'd1 << $urandom_range(14, 40));
      txn(1'($urandom_range(0, 1)), a, size_tab[$urandom_range(0, 9)], rand_line(),
          16'($urandom));
    end
    for (int i = 0; i < 16; i++) txn(1'b0, 56'(i * 16), 3'd7, '0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
